// File: rtl/mcycle_processor.sv
// mcycle_processor: multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT).
// One shared memory port carries instruction fetches, loads and stores.
// Optional debug read port enabled by defining PROC_DBG_PORT_EN.
module mcycle_processor #(
  parameter int          AW       = 16,
  parameter int          NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready,
  output logic          halted,
  output logic          illegal
`ifdef PROC_DBG_PORT_EN
  ,
  input  logic [4:0]    dbg_addr,
  output logic [31:0]   dbg_data
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  state_t          state;
  state_t          stateNext;

  logic [31:0]     pc;
  logic [31:0]     ir;
  logic [31:0]     regA;
  logic [31:0]     regB;
  logic [31:0]     result;
  logic [AW-1:0]   addrReg;
  logic            illegalReg;
  logic            reqRaw;
  logic            weRaw;

  // instruction fields
  logic [5:0]      op;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [5:0]      funct;
  logic [15:0]     imm;
  logic [25:0]     target;
  logic [31:0]     immExt;
  logic            unusedShamt;

  assign op          = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign funct       = ir[5:0];
  assign imm         = ir[15:0];
  assign target      = ir[25:0];
  assign immExt      = {{16{imm[15]}}, imm};
  assign unusedShamt = ^ir[10:6];

  logic isR, isAddi, isLoad, isStore, isBeq, isJ, isHalt;
  logic functOk, opLegal;

  assign isR     = (op == OP_RTYPE);
  assign isAddi  = (op == OP_ADDI);
  assign isLoad  = (op == OP_LW);
  assign isStore = (op == OP_SW);
  assign isBeq   = (op == OP_BEQ);
  assign isJ     = (op == OP_J);
  assign isHalt  = (op == OP_HALT);
  assign functOk = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                   (funct == FN_OR)  || (funct == FN_SLT);
  assign opLegal = (isR && functOk) || isAddi || isLoad || isStore || isBeq || isJ;

  // register file: index 0 and indices beyond NREGS are hard-wired to zero
  logic [31:0]     regFile [1:NREGS-1];
  logic [31:0]     regRead [32];
  logic            wbEn;
  logic [4:0]      wbDest;

  assign wbEn   = (state == WB);
  assign wbDest = isR ? rd : rt;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_read
      if (gi == 0 || gi >= NREGS) begin : g_zero
        assign regRead[gi] = '0;
      end else begin : g_reg
        assign regRead[gi] = regFile[gi];
      end
    end
    for (gi = 1; gi < NREGS; gi++) begin : g_write
      // write-back into one register; writes to $0 never match any gi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regFile[gi] <= '0;
        end else if (wbEn && (wbDest == 5'(gi))) begin
          regFile[gi] <= result;
        end
      end
    end
  endgenerate

`ifdef PROC_DBG_PORT_EN
  assign dbg_data = regRead[dbg_addr];
`endif

  // ALU for R-type operations (operands latched in DECODE)
  logic [31:0] aluR;
  always_comb begin
    aluR = '0;
    case (funct)
      FN_ADD:  aluR = regA + regB;
      FN_SUB:  aluR = regA - regB;
      FN_AND:  aluR = regA & regB;
      FN_OR:   aluR = regA | regB;
      FN_SLT:  aluR = {31'b0, ($signed(regA) < $signed(regB))};
      default: aluR = '0;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= stateNext;
    end
  end

  // next-state and memory-port outputs
  always_comb begin
    stateNext = state;
    reqRaw    = 1'b0;
    weRaw     = 1'b0;
    mem_addr  = {pc[AW-1:2], 2'b00};
    case (state)
      FETCH: begin
        reqRaw = 1'b1;
        if (mem_ready) stateNext = DECODE;
      end
      DECODE: begin
        if (isHalt || !opLegal) stateNext = HALT;
        else                    stateNext = EXEC;
      end
      EXEC: begin
        if (isLoad || isStore)  stateNext = MEM;
        else if (isBeq || isJ)  stateNext = FETCH;
        else                    stateNext = WB;
      end
      MEM: begin
        reqRaw   = 1'b1;
        weRaw    = isStore;
        mem_addr = addrReg;
        if (mem_ready) stateNext = isStore ? FETCH : WB;
      end
      WB:      stateNext = FETCH;
      HALT:    stateNext = HALT;
      default: stateNext = FETCH;
    endcase
    // reset is asynchronous, so the request falls with rst_n rather than
    // waiting for the state register to settle
    mem_req = reqRaw && rst_n;
    mem_we  = weRaw && rst_n;
  end

  assign mem_wdata = regB;
  assign halted    = (state == HALT);
  assign illegal   = illegalReg;

  // datapath registers updated per state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      ir         <= '0;
      regA       <= '0;
      regB       <= '0;
      result     <= '0;
      addrReg    <= '0;
      illegalReg <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        DECODE: begin
          regA <= regRead[rs];
          regB <= regRead[rt];
          if (!isHalt && !opLegal) illegalReg <= 1'b1;
        end
        EXEC: begin
          if (isR) begin
            result <= aluR;
          end else if (isAddi) begin
            result <= regA + immExt;
          end else if (isBeq) begin
            if (regA == regB) pc <= pc + (immExt << 2);
          end else if (isJ) begin
            pc <= {pc[31:28], target, 2'b00};
          end else if (isLoad || isStore) begin
            addrReg <= AW'(regA + immExt) & ~(AW'(3));
          end
        end
        MEM: begin
          if (mem_ready && isLoad) result <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_processor.sv
// tb_mcycle_processor: directed, table-driven bench for mcycle_processor.
// A behavioural memory with per-address stall injection serves the main core;
// a second core (NREGS=8, RESET_PC=0x40) runs from a small ROM.
module tb_mcycle_processor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_we, mem_ready, halted, illegal;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        req8, we8, halted8, illegal8;
  logic [15:0] addr8;
  logic [31:0] wdata8, rom8;

  int          nVec = 0;
  int          nBad = 0;
  int          cyc = 0;

  logic [31:0] mem [256];
  logic [15:0] stallAddr = 16'h0;
  int          stallSet = 0;
  int          stallUsed = 0;
  logic [31:0] rdAddr [$];
  int          rdCyc [$];
  logic [31:0] w80 = 32'hA5A5A5A5;
  logic [31:0] w84 = 32'hA5A5A5A5;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    int          cpi;
  } trace_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } memchk_t;

  mcycle_processor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .halted   (halted),
    .illegal  (illegal)
  );

  mcycle_processor #(.NREGS(8), .RESET_PC(32'h40)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_req  (req8),
    .mem_we   (we8),
    .mem_addr (addr8),
    .mem_wdata(wdata8),
    .mem_rdata(rom8),
    .mem_ready(1'b1),
    .halted   (halted8),
    .illegal  (illegal8)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] encJ(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  localparam logic [31:0] HALT_W = 32'hFC000000;

  // memory model: combinational read, stall injection on one address, write on handshake
  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = !(mem_req && (mem_addr == stallAddr) && (stallUsed < stallSet));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) stallUsed <= 0;
    else if (mem_req && !mem_ready) stallUsed <= stallUsed + 1;
    if (mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // read-handshake monitor (sampled away from the active edge)
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_ready && !mem_we) begin
      rdAddr.push_back(32'(mem_addr));
      rdCyc.push_back(cyc);
    end
  end

  // ROM and store capture for the NREGS=8 core
  always_comb begin
    rom8 = HALT_W;
    case (addr8)
      16'h40:  rom8 = encI(6'h08, 5'd0, 5'd9, 16'd7);
      16'h44:  rom8 = encI(6'h08, 5'd0, 5'd7, 16'd7);
      16'h48:  rom8 = encI(6'h2B, 5'd0, 5'd9, 16'h0080);
      16'h4C:  rom8 = encI(6'h2B, 5'd0, 5'd7, 16'h0084);
      default: rom8 = HALT_W;
    endcase
  end

  always @(posedge clk) begin
    if (req8 && we8 && addr8 == 16'h80) w80 <= wdata8;
    if (req8 && we8 && addr8 == 16'h84) w84 <= wdata8;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic startTest();
    rst_n = 1'b0;
    stallSet = 0;
    stallAddr = 16'h0;
    rdAddr.delete();
    rdCyc.delete();
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
  endtask

  task automatic releaseRst();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitHalt(input string name, input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    check(name, 32'(halted), 32'd1);
  endtask

  trace_t  tr [27];
  memchk_t mc [10];

  initial begin
    logic [31:0] fA [$];
    int          fC [$];
    int          reqSeen;

    // ---------------- main program: expected execution trace ----------------
    tr[0]  = '{32'h00, encI(6'h08, 5'd0, 5'd1, 16'd5),      4};
    tr[1]  = '{32'h04, encI(6'h08, 5'd0, 5'd2, 16'hFFFD),   4};
    tr[2]  = '{32'h08, encR(5'd1, 5'd2, 5'd3, 6'h20),       4};
    tr[3]  = '{32'h0C, encR(5'd2, 5'd1, 5'd4, 6'h2A),       4};
    tr[4]  = '{32'h10, encR(5'd2, 5'd1, 5'd5, 6'h22),       4};
    tr[5]  = '{32'h14, encR(5'd1, 5'd2, 5'd6, 6'h24),       4};
    tr[6]  = '{32'h18, encR(5'd1, 5'd2, 5'd7, 6'h25),       4};
    tr[7]  = '{32'h1C, encR(5'd1, 5'd2, 5'd8, 6'h2A),       4};
    tr[8]  = '{32'h20, encI(6'h08, 5'd0, 5'd0, 16'd7),      4};
    tr[9]  = '{32'h24, encI(6'h2B, 5'd0, 5'd3, 16'h0080),   4};
    tr[10] = '{32'h28, encI(6'h2B, 5'd0, 5'd4, 16'h0084),   4};
    tr[11] = '{32'h2C, encI(6'h2B, 5'd0, 5'd5, 16'h0088),   4};
    tr[12] = '{32'h30, encI(6'h2B, 5'd0, 5'd6, 16'h008C),   4};
    tr[13] = '{32'h34, encI(6'h2B, 5'd0, 5'd7, 16'h0090),   4};
    tr[14] = '{32'h38, encI(6'h2B, 5'd0, 5'd8, 16'h0094),   4};
    tr[15] = '{32'h3C, encI(6'h2B, 5'd0, 5'd0, 16'h0098),   4};
    tr[16] = '{32'h40, encI(6'h23, 5'd0, 5'd9, 16'h03F0),   5};
    tr[17] = '{32'h44, encI(6'h2B, 5'd0, 5'd9, 16'h009C),   4};
    tr[18] = '{32'h48, encI(6'h08, 5'd0, 5'd10, 16'hFFFF),  4};
    tr[19] = '{32'h4C, encI(6'h08, 5'd10, 5'd10, 16'd1),    4};
    tr[20] = '{32'h50, encI(6'h2B, 5'd0, 5'd10, 16'h00A0),  4};
    tr[21] = '{32'h54, encI(6'h08, 5'd2, 5'd11, 16'h8000),  4};
    tr[22] = '{32'h58, encI(6'h2B, 5'd0, 5'd11, 16'h00A4),  4};
    tr[23] = '{32'h5C, encI(6'h04, 5'd1, 5'd2, 16'd5),      3};
    tr[24] = '{32'h60, encI(6'h04, 5'd1, 5'd1, 16'd1),      3};
    tr[25] = '{32'h68, encJ(26'h40),                        3};
    tr[26] = '{32'h100, HALT_W,                             0};

    mc[0] = '{32'h80, 32'h00000002};
    mc[1] = '{32'h84, 32'h00000001};
    mc[2] = '{32'h88, 32'hFFFFFFF8};
    mc[3] = '{32'h8C, 32'h00000005};
    mc[4] = '{32'h90, 32'hFFFFFFFD};
    mc[5] = '{32'h94, 32'h00000000};
    mc[6] = '{32'h98, 32'h00000000};
    mc[7] = '{32'h9C, 32'hCAFEF00D};
    mc[8] = '{32'hA0, 32'h00000000};
    mc[9] = '{32'hA4, 32'hFFFF7FFD};

    startTest();
    #1;
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    for (int k = 0; k < 27; k++) mem[tr[k].pc[9:2]] <= tr[k].insn;
    mem[32'h64 >> 2] <= HALT_W;
    for (int a = 32'h80; a <= 32'hA4; a += 4) mem[a >> 2] <= 32'hA5A5A5A5;
    mem[252] <= 32'hCAFEF00D;
    releaseRst();
    waitHalt("main_halted", 400);

    for (int i = 0; i < rdAddr.size(); i++) begin
      if (rdAddr[i] < 32'h200) begin
        fA.push_back(rdAddr[i]);
        fC.push_back(rdCyc[i]);
      end
    end
    check("main_fetch_count", 32'(fA.size()), 32'd27);
    for (int k = 0; k < 27; k++) begin
      if (k < fA.size()) check($sformatf("fetch_pc[%0d]", k), fA[k], tr[k].pc);
      if (k + 1 < fA.size() && tr[k].cpi != 0)
        check($sformatf("cpi[%0d]", k), 32'(fC[k+1] - fC[k]), 32'(tr[k].cpi));
    end
    if (fA.size() > 3) check("first3_cycles", 32'(fC[3] - fC[0]), 32'd12);
    for (int k = 0; k < 10; k++)
      check($sformatf("mem[%03h]", mc[k].addr), mem[mc[k].addr[9:2]], mc[k].exp);
    check("main_illegal", 32'(illegal), 32'd0);
    reqSeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) reqSeen++;
    end
    check("halt_no_req", 32'(reqSeen), 32'd0);

    // ---------------- beq self-loop and jump ----------------
    startTest();
    mem[0] <= encJ(26'h4);
    mem[4] <= encI(6'h04, 5'd0, 5'd0, 16'hFFFF);
    releaseRst();
    for (int i = 0; i < 50 && rdAddr.size() < 4; i++) @(negedge clk);
    check("loop_reads", 32'(rdAddr.size() >= 4), 32'd1);
    if (rdAddr.size() >= 4) begin
      for (int k = 1; k < 4; k++) begin
        check($sformatf("loop_pc[%0d]", k), rdAddr[k], 32'h10);
        check($sformatf("loop_cpi[%0d]", k), 32'(rdCyc[k] - rdCyc[k-1]), 32'd3);
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(mem_req), 32'd0);
    check("async_rst_we", 32'(mem_we), 32'd0);

    // ---------------- illegal opcode / funct, halt op ----------------
    startTest();
    mem[0] <= 32'hF8000000;
    releaseRst();
    waitHalt("ill_op_halted", 50);
    check("ill_op_illegal", 32'(illegal), 32'd1);
    startTest();
    #1;
    check("rst_clears_illegal", 32'(illegal), 32'd0);
    check("rst_clears_halted", 32'(halted), 32'd0);
    mem[0] <= encR(5'd1, 5'd2, 5'd3, 6'h21);
    releaseRst();
    waitHalt("ill_fn_halted", 50);
    check("ill_fn_illegal", 32'(illegal), 32'd1);

    // ---------------- reset in the middle of a stalled store ----------------
    startTest();
    mem[0] <= encI(6'h2B, 5'd0, 5'd0, 16'h0080);
    mem[4] <= HALT_W;
    mem[32] <= 32'h00000055;
    stallAddr = 16'h0080;
    stallSet = 1000;
    releaseRst();
    for (int i = 0; i < 50 && !(mem_req && mem_we); i++) @(negedge clk);
    check("sw_in_mem", 32'(mem_req && mem_we), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("sw_rst_req_drop", 32'(mem_req), 32'd0);
    check("sw_abandoned", mem[32], 32'h00000055);
    repeat (2) @(posedge clk);
    @(negedge clk);
    stallSet = 0;
    rst_n = 1'b1;
    #1;
    check("post_rst_req", 32'(mem_req), 32'd1);
    check("post_rst_addr", 32'(mem_addr), 32'h0);
    check("post_rst_we", 32'(mem_we), 32'd0);
    check("dut8_reset_pc", 32'(addr8), 32'h40);
    waitHalt("sw_halted", 50);

    // ---------------- load with three wait cycles ----------------
    startTest();
    mem[0] <= encI(6'h23, 5'd0, 5'd5, 16'h0008);
    mem[1] <= encJ(26'h8);
    mem[2] <= 32'hDEADBEEF;
    mem[8] <= encI(6'h2B, 5'd0, 5'd5, 16'h0080);
    mem[9] <= HALT_W;
    stallAddr = 16'h0008;
    stallSet = 3;
    releaseRst();
    waitHalt("lw_halted", 80);
    check("lw_stall_cycles", 32'(stallUsed), 32'd3);
    check("lw_reads", 32'(rdAddr.size() >= 3), 32'd1);
    if (rdAddr.size() >= 3) begin
      check("lw_addr", rdAddr[1], 32'h8);
      check("lw_cycles", 32'(rdCyc[2] - rdCyc[0]), 32'd8);
    end
    check("lw_value", mem[32], 32'hDEADBEEF);

    // ---------------- NREGS=8 core: out-of-range register reads zero ----------------
    for (int i = 0; i < 50 && !halted8; i++) @(negedge clk);
    check("n8_halted", 32'(halted8), 32'd1);
    check("n8_illegal", 32'(illegal8), 32'd0);
    check("n8_reg9", w80, 32'h0);
    check("n8_reg7", w84, 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/mcycle_processor.md
MCYCLE_PROCESSOR -- requirements
Module: mcycle_processor

Interface
REQ-001 SHALL have parameter AW, default 16: byte-address width of the memory port (10..32).
REQ-002 SHALL have parameter NREGS, default 32: implemented registers (2..32); register indices >= NREGS read 0 and ignore writes.
REQ-003 SHALL have parameter RESET_PC, default 0: PC value after reset, word aligned.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mem_req  output  1  memory request valid.
REQ-007 SHALL have port mem_we  output  1  1 = write, 0 = read; meaningful only while mem_req is high.
REQ-008 SHALL have port mem_addr  output  AW  byte address, bits [1:0] always 0.
REQ-009 SHALL have port mem_wdata  output  32  store data.
REQ-010 SHALL have port mem_rdata  input  32  read data, valid in the cycle mem_ready is high.
REQ-011 SHALL have port mem_ready  input  1  completes the pending request at the clock edge where mem_req and mem_ready are both high.
REQ-012 SHALL have port halted  output  1  high in HALT state.
REQ-013 SHALL have port illegal  output  1  sticky; set when an unsupported opcode or funct is decoded.

Function
REQ-014 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-015 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=pc[AW-1:0], and hold these until handshake; on handshake it SHALL latch IR=mem_rdata, set pc=pc+4, and go to DECODE.
REQ-016 DECODE SHALL latch A=reg[rs] and B=reg[rt]; reg[0] SHALL always read 0.
REQ-017 Supported set: R-type (op 0x00) funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); addi 0x08; lw 0x23; sw 0x2B; beq 0x04; j 0x02; halt 0x3F.
REQ-018 Any other op or funct SHALL set illegal and go to HALT; halt op SHALL go to HALT without setting illegal.
REQ-019 Arithmetic SHALL wrap modulo 2^32 with no overflow trap; immediates SHALL be sign-extended to 32 bits.
REQ-020 EXEC for beq SHALL set pc=pc+(signext(imm)<<2) when A==B, then go to FETCH.
REQ-021 EXEC for j SHALL set pc={pc[31:28],target,2'b00}, then go to FETCH.
REQ-022 EXEC for lw/sw SHALL compute addr=A+signext(imm), truncate it to AW bits, force bits [1:0] to 0, and go to MEM.
REQ-023 MEM SHALL hold mem_req=1, mem_we=(op==sw), and mem_wdata=B until handshake; sw SHALL then go to FETCH and lw SHALL latch mem_rdata and go to WB.
REQ-024 WB SHALL write rd (R-type) or rt (addi, lw); writes to index 0 SHALL be discarded; then go to FETCH.
REQ-025 With zero-wait memory, cycles per instruction SHALL be: R-type/addi 4, lw 5, sw 4, beq 3, j 3, each extended by one cycle per cycle mem_ready is low.
REQ-026 mem_req SHALL be 0 in DECODE, EXEC, WB and HALT; mem_ready while mem_req is low SHALL be ignored.
REQ-027 HALT SHALL be left only by reset.

Reset
REQ-028 Asserting rst_n low SHALL, without waiting for clk: set state=FETCH, pc=RESET_PC, all registers, IR, A and B to 0, and mem_req, mem_we, halted and illegal to 0.
REQ-029 A pending memory transaction SHALL be abandoned on reset; after release the first request SHALL be a fetch from RESET_PC.

Configuration
REQ-030 With PROC_DBG_PORT_EN defined, SHALL add input dbg_addr [4:0] and output dbg_data [31:0]: combinational read of reg[dbg_addr] with the same index-0 and >=NREGS rules, independent of FSM state.
REQ-031 Without PROC_DBG_PORT_EN, those ports SHALL be absent and function SHALL be otherwise identical.

Verification
REQ-032 Zero-wait memory; program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> $3 = 2 after 12 cycles; slt $4,$2,$1 -> $4 = 1.
REQ-033 lw $5,8($0) with mem[8]=0xDEADBEEF and mem_ready low for 3 cycles in MEM -> $5 = 0xDEADBEEF; lw takes 8 cycles; mem_addr held at 0x8 throughout the wait.
REQ-034 beq $0,$0,-1 at pc 0x10 -> next fetch at 0x10; j 0x40 -> next fetch at 0x100.
REQ-035 Fetch of word 0xFC000000 -> halted = 1, illegal = 0, no further mem_req; opcode 0x3E -> halted = 1, illegal = 1.
REQ-036 rst_n pulled low mid-MEM of sw -> mem_req drops before the next clk edge; after release, mem_addr = RESET_PC with mem_we = 0.
REQ-037 addi $0,$0,7 then read $0 via the debug port (PROC_DBG_PORT_EN defined) -> 0; with NREGS=8, write to $9 then read $9 -> 0.
